// File: rtl/adder_share_arb.sv
// Round-robin arbiter that lets NREQ requesters share one external combinational adder,
// with a single registered result slot. Optional statistics counters: ADDER_ARB_STATS_EN.
module adder_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH:0]        add_s,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH:0]        rsp_sum,
  output logic [IDW-1:0]        rsp_id
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [31:0]           stat_ops,
  output logic [31:0]           stat_stall
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q;
  logic           slot_free;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic           accept;

  // Modular increment of a requester index; ptr never leaves 0..NREQ-1.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s -= NREQ;
    return IDW'(s);
  endfunction

  assign rsp_valid = (state_q == FULL);
  assign slot_free = ~rsp_valid | rsp_ready;

  // Offsets are walked from farthest to nearest so the requester closest to ptr wins.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req_valid[wrap_idx(ptr_q, off)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(ptr_q, off);
      end
    end
  end

  // rst_n gates the grant so req_ready drops the instant reset asserts.
  assign accept = grant_found & slot_free & rst_n;

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
      add_a = req_a[grant_idx*WIDTH +: WIDTH];
      add_b = req_b[grant_idx*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) ptr_q <= wrap_idx(grant_idx, 1);
    end
  end

  // NOTE: the result payload is reset too, because rsp_sum/rsp_id must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum <= '0;
      rsp_id  <= '0;
    end else if (accept) begin
      rsp_sum <= add_s;
      rsp_id  <= grant_idx;
    end
  end

`ifdef ADDER_ARB_STATS_EN
  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (accept && stat_ops != 32'hFFFF_FFFF) stat_ops <= stat_ops + 32'd1;
      if (rsp_valid && !rsp_ready && stat_stall != 32'hFFFF_FFFF)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: directed scenarios plus random traffic
// compared every cycle against a queue-free behavioural model of the arbiter.
module tb_adder_share_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 64;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [WIDTH-1:0]      add_a, add_b;
  logic [WIDTH:0]        add_s;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [WIDTH:0]        rsp_sum;
  logic [IDW-1:0]        rsp_id;
`ifdef ADDER_ARB_STATS_EN
  logic [31:0]           stat_ops, stat_stall;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: the result slot and the round-robin pointer as plain integers.
  int             m_ptr = 0;
  bit             m_full = 0;
  logic [WIDTH:0] m_sum = '0;
  int             m_id = 0;
  int             m_last_g = -1;
  longint         m_ops = 0;
  longint         m_stall = 0;

  always #5 clk = ~clk;

  // Stand-in for the external combinational adder.
  assign add_s = {1'b0, add_a} + {1'b0, add_b};

  adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id)
`ifdef ADDER_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
  );

  task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_full = 0; m_sum = '0; m_id = 0; m_last_g = -1; m_ops = 0; m_stall = 0;
  endfunction

  function automatic logic [WIDTH-1:0] opnd(input logic [NREQ*WIDTH-1:0] v, input int k);
    return v[k*WIDTH +: WIDTH];
  endfunction

  // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    bit             free;
    int             g;
    logic [NREQ-1:0] exp_ready;
    logic [WIDTH-1:0] ea, eb;
    @(negedge clk);
    free = !m_full || rsp_ready;
    g = -1;
    for (int i = 0; i < NREQ; i++)
      if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
    exp_ready = '0; ea = '0; eb = '0;
    if (free && g >= 0) begin
      exp_ready[g] = 1'b1;
      ea = opnd(req_a, g);
      eb = opnd(req_b, g);
    end
    check("req_ready", {{(WIDTH+1-NREQ){1'b0}}, req_ready}, {{(WIDTH+1-NREQ){1'b0}}, exp_ready});
    check("add_a", {1'b0, add_a}, {1'b0, ea});
    check("add_b", {1'b0, add_b}, {1'b0, eb});
    check("rsp_valid", {{WIDTH{1'b0}}, rsp_valid}, {{WIDTH{1'b0}}, m_full});
    if (m_full) begin
      check("rsp_sum", rsp_sum, m_sum);
      check("rsp_id", {{(WIDTH+1-IDW){1'b0}}, rsp_id}, (WIDTH+1)'(m_id));
    end
`ifdef ADDER_ARB_STATS_EN
    check("stat_ops", {33'd0, stat_ops}, (WIDTH+1)'(m_ops));
    check("stat_stall", {33'd0, stat_stall}, (WIDTH+1)'(m_stall));
`endif
    if (m_full && !rsp_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (free && g >= 0) begin
      m_full = 1;
      m_sum = {1'b0, opnd(req_a, g)} + {1'b0, opnd(req_b, g)};
      m_id = g;
      m_last_g = g;
      m_ptr = (g + 1) % NREQ;
      if (m_ops < 64'hFFFF_FFFF) m_ops++;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before any clock.
  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    check("rst rsp_valid", {{WIDTH{1'b0}}, rsp_valid}, '0);
    check("rst req_ready", {{(WIDTH+1-NREQ){1'b0}}, req_ready}, '0);
    check("rst rsp_sum", rsp_sum, '0);
    check("rst rsp_id", {{(WIDTH+1-IDW){1'b0}}, rsp_id}, '0);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_ops(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[k*WIDTH +: WIDTH] = a;
    req_b[k*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    int exp_seq[8];
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Reset state with every requester asking.
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset rsp_valid", {{WIDTH{1'b0}}, rsp_valid}, '0);
    check("reset req_ready", {{(WIDTH+1-NREQ){1'b0}}, req_ready}, '0);
    check("reset add_a", {1'b0, add_a}, '0);
    check("reset rsp_sum", rsp_sum, '0);
    #1 rst_n = 1'b1;
    model_reset();

    // Fairness: four persistent requesters drain in strict rotation with no bubble.
    for (int k = 0; k < NREQ; k++) set_ops(k, 64'(k * 100), 64'(k + 7));
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("fair rsp_valid", {{WIDTH{1'b0}}, rsp_valid}, 65'd1);
      check("fair rsp_id", {{(WIDTH+1-IDW){1'b0}}, rsp_id}, (WIDTH+1)'(exp_seq[i]));
    end

    // Single op with carry-out.
    req_valid = 4'b0001;
    set_ops(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    cycle();
    check("carry rsp_sum", rsp_sum, 65'h1_0000_0000_0000_0000);
    check("carry rsp_id", {{(WIDTH+1-IDW){1'b0}}, rsp_id}, '0);

    // Backpressure: hold result 5 for 5 stalled cycles, then resume with no bubble.
    set_ops(0, 64'd2, 64'd3);
    cycle();
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall rsp_sum", rsp_sum, 65'd5);
      check("stall req_ready", {{(WIDTH+1-NREQ){1'b0}}, req_ready}, '0);
    end
    rsp_ready = 1'b1;
    cycle();
    check("resume rsp_valid", {{WIDTH{1'b0}}, rsp_valid}, 65'd1);
    check("resume rsp_id", {{(WIDTH+1-IDW){1'b0}}, rsp_id}, 65'd1);

    // Wrap: grant 2 moves the pointer to 3; 0101 then yields 0 followed by 2.
    req_valid = 4'b0100;
    cycle();
    check("wrap g2", (WIDTH+1)'(m_last_g), 65'd2);
    req_valid = 4'b0101;
    cycle();
    check("wrap id0", {{(WIDTH+1-IDW){1'b0}}, rsp_id}, 65'd0);
    cycle();
    check("wrap id2", {{(WIDTH+1-IDW){1'b0}}, rsp_id}, 65'd2);

    // Reset during a stall discards the held result.
    req_valid = 4'b0001;
    cycle();
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    cycle();
    reset_pulse();
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    cycle();
    check("post-rst no rsp", {{WIDTH{1'b0}}, rsp_valid}, '0);
    req_valid = 4'b1010;
    cycle();
    check("post-rst grant", {{(WIDTH+1-IDW){1'b0}}, rsp_id}, 65'd1);

`ifdef ADDER_ARB_STATS_EN
    // Ten accepts followed by three stall cycles.
    reset_pulse();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (10) cycle();
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    repeat (3) cycle();
    check("stat_ops=10", {33'd0, stat_ops}, 65'd10);
    check("stat_stall=3", {33'd0, stat_stall}, 65'd3);
    rsp_ready = 1'b1;
    cycle();
`endif

    // Random traffic including extreme operands and request withdrawal.
    for (int n = 0; n < 500; n++) begin
      req_valid = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom_range(0, 7) == 0)
          set_ops(k, '1, {$urandom, $urandom});
        else
          set_ops(k, {$urandom, $urandom}, {$urandom, $urandom});
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
